// File: rtl/arm_command_bus_master_pkg.sv
// Shared constants for the arm command bus master.
// FSM encodings, reply codes and command field positions.
package arm_command_bus_master_pkg;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_GET_LEN    = 3'd1;
  localparam logic [2:0] S_GET_DATA   = 3'd2;
  localparam logic [2:0] S_BUS_ACCESS = 3'd3;
  localparam logic [2:0] S_BUS_GAP    = 3'd4;
  localparam logic [2:0] S_SEND_SIZE  = 3'd5;
  localparam logic [2:0] S_SEND_DATA  = 3'd6;
  localparam logic [2:0] S_SEND_ACK   = 3'd7;

  localparam logic [7:0] REPLY_BAD_LEN = 8'hFF;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_MSB = 6;
  localparam int MAX_LEN      = 4;

  // Peripherals may report more than a word; only MAX_LEN bytes exist.
  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    return (s > 3'(MAX_LEN)) ? 3'(MAX_LEN) : s;
  endfunction

endpackage

// File: rtl/arm_cmd_timeout.sv
// Loadable down-counter with an expire flag.
// Used as the inter-byte timeout of the command parser.
module arm_cmd_timeout #(
  parameter int unsigned LOAD = 120000,
  parameter int unsigned W    = $clog2(LOAD + 1)
) (
  input  logic clk_12MHz,
  input  logic reset,
  input  logic load,
  output logic expired
);

  logic [W-1:0] cnt;

  assign expired = (cnt == '0);

  // Reload on every accepted byte, otherwise count down to zero.
  always_ff @(posedge clk_12MHz) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= W'(LOAD);
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

endmodule

// File: rtl/arm_command_bus_master.sv
// Byte-stream command parser driving the arm peripheral bus.
// Parses host commands, runs one bus access, serializes the reply.
module arm_command_bus_master
  import arm_command_bus_master_pkg::*;
#(
  parameter int unsigned SELECT_HOLD = 4,
  parameter int unsigned TIMEOUT     = 120000
) (
  input  logic        clk_12MHz,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  inout  wire  [31:0] databus,
  input  logic [2:0]  reg_size,
  output logic [7:0]  register_addr,
  output logic        rw,
  output logic        select
);

  localparam int HW = $clog2(SELECT_HOLD + 1);

  logic [2:0]    state;
  logic [31:0]   word;
  logic [31:0]   rdata;
  logic [2:0]    len;
  logic [2:0]    cnt;
  logic [2:0]    rem;
  logic [2:0]    size_q;
  logic [HW-1:0] hold;
  logic          expired;
  logic          rx_fire;
  logic          tx_fire;

  assign rx_ready = (state == S_IDLE) ||
                    (state == S_GET_LEN) ||
                    (state == S_GET_DATA);
  assign rx_fire  = rx_valid & rx_ready;
  assign tx_fire  = tx_valid & tx_ready;

  assign databus = (select & ~rw) ? word : 32'bz;

  arm_cmd_timeout #(
    .LOAD(TIMEOUT)
  ) u_timeout (
    .clk_12MHz(clk_12MHz),
    .reset    (reset),
    .load     (rx_fire),
    .expired  (expired)
  );

  // Command parser, bus sequencer and reply serializer.
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      state         <= S_IDLE;
      select        <= 1'b0;
      rw            <= 1'b1;
      register_addr <= 8'h00;
      tx_valid      <= 1'b0;
      tx_data       <= 8'h00;
      word          <= '0;
      rdata         <= '0;
      len           <= '0;
      cnt           <= '0;
      rem           <= '0;
      size_q        <= '0;
      hold          <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rx_fire) begin
            register_addr <= {1'b0, rx_data[CMD_ADDR_MSB:0]};
            rw            <= rx_data[CMD_RW_BIT];
            hold          <= '0;
            state         <= rx_data[CMD_RW_BIT] ?
                             S_BUS_ACCESS : S_GET_LEN;
          end
        end
        S_GET_LEN: begin
          if (rx_fire) begin
            if (rx_data >= 8'd1 &&
                rx_data <= 8'(MAX_LEN)) begin
              len   <= rx_data[2:0];
              cnt   <= '0;
              word  <= '0;
              state <= S_GET_DATA;
            end else begin
              tx_data  <= REPLY_BAD_LEN;
              tx_valid <= 1'b1;
              state    <= S_SEND_ACK;
            end
          end else if (expired) begin
            state <= S_IDLE;
          end
        end
        S_GET_DATA: begin
          if (rx_fire) begin
            word[8*cnt[1:0] +: 8] <= rx_data;
            cnt <= cnt + 3'd1;
            if (cnt + 3'd1 == len) begin
              hold  <= '0;
              state <= S_BUS_ACCESS;
            end
          end else if (expired) begin
            state <= S_IDLE;
          end
        end
        S_BUS_ACCESS: begin
          // First cycle is address setup; select then holds.
          if (hold == HW'(SELECT_HOLD)) begin
            select <= 1'b0;
            size_q <= reg_size;
            rdata  <= databus;
            state  <= S_BUS_GAP;
          end else begin
            select <= 1'b1;
            hold   <= hold + HW'(1);
          end
        end
        S_BUS_GAP: begin
          tx_valid <= 1'b1;
          if (rw) begin
            tx_data <= {5'b0, size_q};
            rem     <= clamp_size(size_q);
            state   <= S_SEND_SIZE;
          end else begin
            tx_data <= {5'b0, len};
            state   <= S_SEND_ACK;
          end
        end
        S_SEND_SIZE: begin
          if (tx_fire) begin
            if (size_q == 3'd0) begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
            end else begin
              tx_data <= rdata[7:0];
              rdata   <= {8'h00, rdata[31:8]};
              state   <= S_SEND_DATA;
            end
          end
        end
        S_SEND_DATA: begin
          if (tx_fire) begin
            if (rem == 3'd1) begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
            end else begin
              rem     <= rem - 3'd1;
              tx_data <= rdata[7:0];
              rdata   <= {8'h00, rdata[31:8]};
            end
          end
        end
        S_SEND_ACK: begin
          if (tx_fire) begin
            tx_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_command_bus_master.sv
// Directed bench for arm_command_bus_master.
// Peripheral model on the bus, host byte tasks, reply checks.
module tb_arm_command_bus_master;

  logic        clk_12MHz = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b0;
  wire         rx_ready;
  wire  [7:0]  tx_data;
  wire         tx_valid;
  wire  [31:0] databus;
  wire  [2:0]  reg_size;
  wire  [7:0]  register_addr;
  wire         rw;
  wire         select;

  int checks = 0;
  int failures = 0;

  arm_command_bus_master #(
    .SELECT_HOLD(4),
    .TIMEOUT    (200)
  ) dut (
    .clk_12MHz    (clk_12MHz),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .databus      (databus),
    .reg_size     (reg_size),
    .register_addr(register_addr),
    .rw           (rw),
    .select       (select)
  );

  always #41 clk_12MHz = ~clk_12MHz;

  function automatic logic [34:0] periph(input logic [7:0] a);
    case (a)
      8'h10:   return {3'd4, 32'h0000_0000};
      8'h12:   return {3'd4, 32'h0000_2EE0};
      8'h13:   return {3'd2, 32'h0000_1234};
      8'h14:   return {3'd6, 32'h1122_3344};
      default: return {3'd0, 32'h0000_0000};
    endcase
  endfunction

  wire [34:0] pr = periph(register_addr);
  assign reg_size = select ? pr[34:32] : 3'd0;
  assign databus  = (select & rw) ? pr[31:0] : 32'bz;

  int          sel_count = 0;
  int          run = 0;
  int          last_run = 0;
  int          setup_err = 0;
  int          wdata_err = 0;
  logic        sel_d = 1'b0;
  logic [7:0]  addr_d = 8'h00;
  logic        rw_d = 1'b1;
  logic [7:0]  seen_addr = 8'h00;
  logic        seen_rw = 1'b0;
  logic [31:0] seen_wdata = 32'h0;

  always @(negedge clk_12MHz) begin
    if (select && !sel_d) begin
      sel_count++;
      run = 0;
      if (register_addr != addr_d || rw != rw_d) setup_err++;
      seen_addr = register_addr;
      seen_rw   = rw;
      if (!rw) seen_wdata = databus;
    end
    if (select) begin
      run++;
      if (register_addr != seen_addr || rw != seen_rw) setup_err++;
      if (!rw && databus != seen_wdata) wdata_err++;
    end
    if (!select && sel_d) last_run = run;
    sel_d  = select;
    addr_d = register_addr;
    rw_d   = rw;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk_12MHz);
      if (rx_ready) begin
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk_12MHz);
        #1;
        rx_valid = 1'b0;
        done = 1'b1;
      end
    end
    check("rx_accept", done, 1);
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    logic       got;
    logic [7:0] d;
    got = 1'b0;
    d   = 8'h00;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk_12MHz);
      if (tx_valid) begin
        d = tx_data;
        tx_ready = 1'b1;
        @(posedge clk_12MHz);
        #1;
        tx_ready = 1'b0;
        got = 1'b1;
      end
    end
    check({tag, "_seen"}, got, 1);
    check(tag, d, exp);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk_12MHz);
  endtask

  int          base;
  int          unstable;
  logic        hit;
  logic [7:0]  d0;

  initial begin
    repeat (3) @(negedge clk_12MHz);
    check("rst_select", select, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_rw", rw, 1);
    check("rst_addr", register_addr, 8'h00);
    check("rst_rx_ready", rx_ready, 1);
    reset = 1'b0;
    idle_cycles(2);

    // Single-byte write.
    base = sel_count;
    send_byte(8'h10);
    send_byte(8'h01);
    send_byte(8'hAA);
    recv_byte("wr1_ack", 8'h01);
    check("wr1_nsel", sel_count - base, 1);
    check("wr1_run", last_run, 4);
    check("wr1_addr", seen_addr, 8'h10);
    check("wr1_rw", seen_rw, 0);
    check("wr1_wdata", seen_wdata, 32'h0000_00AA);

    // Three-byte write, upper byte zero.
    send_byte(8'h11);
    send_byte(8'h03);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    recv_byte("wr3_ack", 8'h03);
    check("wr3_wdata", seen_wdata, 32'h0003_0201);
    check("wr3_addr", seen_addr, 8'h11);

    // Four-byte read.
    send_byte(8'h92);
    recv_byte("rd_size", 8'h04);
    recv_byte("rd_b0", 8'hE0);
    recv_byte("rd_b1", 8'h2E);
    recv_byte("rd_b2", 8'h00);
    recv_byte("rd_b3", 8'h00);
    check("rd_addr", seen_addr, 8'h12);
    check("rd_rw", seen_rw, 1);
    check("rd_run", last_run, 4);

    // Unmapped read gives a lone zero.
    send_byte(8'h9F);
    recv_byte("unm_size", 8'h00);
    idle_cycles(10);
    check("unm_tx_idle", tx_valid, 0);
    check("unm_rx_ready", rx_ready, 1);

    // Bad lengths.
    base = sel_count;
    send_byte(8'h05);
    send_byte(8'h00);
    recv_byte("len0_reply", 8'hFF);
    send_byte(8'h05);
    send_byte(8'h05);
    recv_byte("len5_reply", 8'hFF);
    idle_cycles(10);
    check("badlen_nsel", sel_count - base, 0);

    // Oversized peripheral size clamps to four bytes.
    send_byte(8'h94);
    recv_byte("clamp_size", 8'h06);
    recv_byte("clamp_b0", 8'h44);
    recv_byte("clamp_b1", 8'h33);
    recv_byte("clamp_b2", 8'h22);
    recv_byte("clamp_b3", 8'h11);
    idle_cycles(10);
    check("clamp_tx_idle", tx_valid, 0);

    // Gap shorter than the timeout keeps the command alive.
    send_byte(8'h11);
    send_byte(8'h01);
    idle_cycles(150);
    send_byte(8'h55);
    recv_byte("slow_ack", 8'h01);
    check("slow_wdata", seen_wdata, 32'h0000_0055);

    // Stalled write is discarded silently.
    base = sel_count;
    send_byte(8'h13);
    send_byte(8'h04);
    send_byte(8'h01);
    idle_cycles(300);
    check("to_nsel", sel_count - base, 0);
    check("to_tx_idle", tx_valid, 0);
    send_byte(8'h93);
    recv_byte("to_rd_size", 8'h02);
    recv_byte("to_rd_b0", 8'h34);
    recv_byte("to_rd_b1", 8'h12);
    check("to_rd_addr", seen_addr, 8'h13);

    // Transmitter back-pressure.
    send_byte(8'h92);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk_12MHz);
      hit = tx_valid;
    end
    check("stall_valid", hit, 1);
    d0 = tx_data;
    unstable = 0;
    repeat (50) begin
      @(negedge clk_12MHz);
      if (!tx_valid || tx_data != d0) unstable++;
    end
    check("stall_stable", unstable, 0);
    recv_byte("stall_size", 8'h04);
    recv_byte("stall_b0", 8'hE0);
    recv_byte("stall_b1", 8'h2E);
    recv_byte("stall_b2", 8'h00);
    recv_byte("stall_b3", 8'h00);

    // Reset while select is high.
    send_byte(8'h92);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk_12MHz);
      hit = select;
    end
    check("rstmid_sel_seen", hit, 1);
    reset = 1'b1;
    @(negedge clk_12MHz);
    check("rstmid_select", select, 0);
    check("rstmid_tx_valid", tx_valid, 0);
    check("rstmid_rw", rw, 1);
    check("rstmid_addr", register_addr, 8'h00);
    reset = 1'b0;
    idle_cycles(20);
    check("rstmid_no_reply", tx_valid, 0);
    send_byte(8'h93);
    recv_byte("post_rst_size", 8'h02);
    recv_byte("post_rst_b0", 8'h34);
    recv_byte("post_rst_b1", 8'h12);

    check("setup_hold", setup_err, 0);
    check("wdata_stable", wdata_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arm_command_bus_master.md
Name: arm_command_bus_master

Overview:
- Byte-stream command parser that sits directly upstream of the arm axis peripherals.
- Consumes bytes from the host UART receiver and turns each command into one register access on the shared peripheral bus (databus / register_addr / rw / select / reg_size).
- Returns a reply byte stream to the UART transmitter.
- One instance serves all axis peripherals on the bus.

Parameters:
- SELECT_HOLD, 4, cycles select is held high per access (min 3, since peripherals latch on the registered select edge).
- TIMEOUT, 120000, idle cycles allowed between bytes of one command before it is silently discarded (10 ms at 12 MHz).

Ports:
- clk_12MHz  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  rx_data valid; byte consumed when rx_valid & rx_ready.
- rx_ready  output  1  high only in command-receiving states.
- tx_data  output  8  reply byte.
- tx_valid  output  1  tx_data valid; held until accepted.
- tx_ready  input  1  transmitter accepts on tx_valid & tx_ready.
- databus  inout  32  peripheral data bus; driven only while select & ~rw, otherwise high-Z.
- reg_size  input  3  byte size returned by the addressed peripheral while select is high.
- register_addr  output  8  peripheral register address.
- rw  output  1  0 = write, 1 = read.
- select  output  1  access strobe.

Behaviour:
- Command byte C: C[7] = rw, C[6:0] = register address (register_addr = {1'b0, C[6:0]}).
- Read command: the single byte C.
- Write command: C, then length L (1..4), then L data bytes, LSB first. Unsupplied upper bytes are zero.
- FSM states: IDLE, GET_LEN, GET_DATA, BUS_ACCESS, BUS_GAP, SEND_SIZE, SEND_DATA, SEND_ACK.
- IDLE: rx_ready = 1. On a byte, latch addr and rw.
  - rw = 1 → BUS_ACCESS.
  - rw = 0 → GET_LEN.
- GET_LEN:
  - L in 1..4 → GET_DATA with byte counter = 0.
  - Otherwise → SEND_ACK with reply 0xFF; no bus access occurs.
- GET_DATA: shift each byte into word[8*n +: 8]. After the L-th byte → BUS_ACCESS.
- Timeout: a counter resets on every accepted byte. In GET_LEN/GET_DATA, reaching TIMEOUT → IDLE with no reply and no bus access.
- BUS_ACCESS:
  - select = 1 for exactly SELECT_HOLD cycles.
  - register_addr and rw are stable from one cycle before select rises until select falls.
  - For writes, databus = word for the whole hold.
  - For reads, databus and reg_size are sampled on the last held cycle.
- BUS_GAP: select = 0 for one cycle, then:
  - read → SEND_SIZE;
  - write → SEND_ACK with reply = L.
- SEND_SIZE: present reg_size, zero-extended to 8 bits.
  - Size 0 (unmapped address) → IDLE after acceptance.
  - Otherwise → SEND_DATA.
- SEND_DATA: send sampled size bytes, LSB first. Sizes above 4 are clamped to 4. → IDLE.
- SEND_ACK: send one byte. → IDLE.
- tx handshake: tx_data is stable while tx_valid & ~tx_ready. No timeout applies while waiting on tx_ready.
- rx_ready = 0 in BUS_ACCESS, BUS_GAP and all SEND states. Bytes arriving then are not consumed; the upstream FIFO holds them.
- Reset: state IDLE, select = 0, rw = 1, register_addr = 0, databus high-Z, tx_valid = 0, tx_data = 0, counters = 0.
- Reset mid-access: select drops on the next edge and no reply is sent.
- Back-to-back commands: minimum select-low time between accesses is one cycle (BUS_GAP), guaranteed.

Decomposition:
- Shared package holds:
  - FSM state encodings;
  - reply constants: REPLY_BAD_LEN = 8'hFF;
  - command field positions: CMD_RW_BIT = 7, CMD_ADDR_MSB = 6;
  - MAX_LEN = 4.
- One natural sub-module: arm_cmd_timeout (loadable down-counter with expire flag), reused for the inter-byte timeout.
- Parser, bus sequencer and reply serializer stay in one FSM.

Test Plan:
- Write 0x10 / len 1 / 0xAA with a peripheral model at 0x10: select high 4 cycles, register_addr = 0x10, rw = 0, databus = 0x000000AA during select → reply 0x01.
- Read 0x92 (rw = 1, addr 0x12), peripheral returns size 4, data 0x00002EE0 → replies 0x04, 0xE0, 0x2E, 0x00, 0x00; databus never driven by the master.
- Read unmapped 0x9F, reg_size = 0 → single reply 0x00, then IDLE.
- Write with L = 0, and separately L = 5 → reply 0xFF, select never asserted.
- Send 0x13, 0x04, 0x01, then stall more than 120000 cycles → no select, no reply. Then a read of 0x93 works normally.
- tx_ready held low 50 cycles during a read reply → tx_data stable, no bytes lost. Reset asserted during BUS_ACCESS → select 0 next cycle, tx_valid 0, databus high-Z.
